// File: rtl/burst_rr_arbiter.sv
// Round-robin arbiter granting one requester a whole burst on a shared beat-acknowledged resource.
// Latency: request sampled in IDLE is granted one cycle later; one mandatory IDLE cycle after each burst.
// Backpressure: beat_ack paces the burst; TIMEOUT consecutive ack-less BUSY cycles abort it.
module burst_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 16,
    localparam int IDW    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*LEN_W-1:0] req_len,
    input  logic                     beat_ack,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [IDW-1:0]           gnt_id,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err
);

    localparam int IW1 = IDW + 1;
    localparam int RW  = LEN_W + 1;

    typedef enum logic {IDLE, BUSY} stateE;

    stateE           state;
    logic [IDW-1:0]  ptr;
    logic [RW-1:0]   remaining;
    logic [7:0]      stallCnt;

    logic            found;
    logic [IDW-1:0]  pick;
    logic [IW1-1:0]  cand;
    logic [LEN_W-1:0] pickLen;
    logic [RW-1:0]   loadLen;
    logic            lastBeat;
    logic            stallOut;
    logic [IDW-1:0]  nextPtr;

    // First requesting index at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, ptr} + IW1'(i);
            if (cand >= IW1'(NUM_REQ)) begin
                cand = cand - IW1'(NUM_REQ);
            end
            if (!found && req[cand[IDW-1:0]]) begin
                found = 1'b1;
                pick  = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        pickLen = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (pick == IDW'(j)) begin
                pickLen = req_len[j*LEN_W +: LEN_W];
            end
        end
    end

    assign loadLen  = (pickLen == '0) ? RW'(1) : {1'b0, pickLen};
    assign lastBeat = (state == BUSY) && beat_ack && (remaining == RW'(1));
    assign stallOut = (state == BUSY) && !beat_ack && (stallCnt == 8'(TIMEOUT - 1));
    assign nextPtr  = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);

    // Pulses are suppressed while reset is asserted so a discarded burst never reports an ending.
    assign done        = rst_n && lastBeat;
    assign timeout_err = rst_n && stallOut;
    assign busy        = (state == BUSY);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            stallCnt  <= '0;
            gnt       <= '0;
            gnt_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        state     <= BUSY;
                        gnt       <= NUM_REQ'(1) << pick;
                        gnt_id    <= pick;
                        remaining <= loadLen;
                        stallCnt  <= '0;
                    end
                end
                BUSY: begin
                    if (beat_ack) begin
                        remaining <= remaining - RW'(1);
                        stallCnt  <= '0;
                    end else begin
                        stallCnt  <= stallCnt + 8'd1;
                    end
                    if (lastBeat || stallOut) begin
                        state    <= IDLE;
                        gnt      <= '0;
                        gnt_id   <= '0;
                        ptr      <= nextPtr;
                        stallCnt <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_burst_rr_arbiter.sv
// Bench for burst_rr_arbiter: directed scenarios then random traffic against a burst-level reference model.
module tb_burst_rr_arbiter;

    localparam int N  = 4;
    localparam int LW = 4;
    localparam int TO = 16;

    localparam int EV_GRANT = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_TOUT  = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] req_len = '0;
    logic            beat_ack = 1'b0;
    logic [N-1:0]    gnt;
    logic [1:0]      gnt_id;
    logic            busy;
    logic            done;
    logic            timeout_err;

    burst_rr_arbiter #(.NUM_REQ(N), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .beat_ack(beat_ack),
        .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int id;
        int cyc;
    } ev_t;

    ev_t q[$];
    int  checks = 0;
    int  failures = 0;
    bit  checkEn = 0;

    // Burst-level reference: who owns the resource, beats left, quiet cycles, next priority index.
    bit mBusy = 0;
    int mOwner = 0;
    int mLeft = 0;
    int mQuiet = 0;
    int mPtr = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model();
        int w;
        int len;
        if (!rst_n) begin
            mBusy = 0;
            mPtr = 0;
            return;
        end
        if (mBusy) begin
            bit ended = 0;
            if (beat_ack) begin
                if (mLeft == 1) begin
                    q.push_back('{EV_DONE, mOwner, cyc});
                    ended = 1;
                end else begin
                    mLeft--;
                    mQuiet = 0;
                end
            end else if (mQuiet == TO - 1) begin
                q.push_back('{EV_TOUT, mOwner, cyc});
                ended = 1;
            end else begin
                mQuiet++;
            end
            if (ended) begin
                mBusy = 0;
                mPtr = (mOwner + 1) % N;
            end
        end else if (req != '0) begin
            w = -1;
            for (int k = 0; k < N; k++) begin
                int c = (mPtr + k) % N;
                if (w < 0 && req[c]) w = c;
            end
            len = int'(req_len[w*LW +: LW]);
            mBusy = 1;
            mOwner = w;
            mLeft = (len == 0) ? 1 : len;
            mQuiet = 0;
            q.push_back('{EV_GRANT, w, cyc + 1});
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N*LW-1:0] l, input logic a, input logic rn);
        @(posedge clk);
        #1;
        req = r;
        req_len = l;
        beat_ack = a;
        rst_n = rn;
        model();
    endtask

    task automatic expectEv(input string name, input int kind, input int id);
        ev_t e;
        if (q.size() == 0) begin
            chk({name, "_unexpected"}, 1, 0);
            return;
        end
        e = q.pop_front();
        chk({name, "_kind"}, kind, e.kind);
        chk({name, "_id"}, id, e.id);
        chk({name, "_cycle"}, cyc, e.cyc);
    endtask

    // Monitor: samples mid-cycle, checks invariants and pops expected events as the DUT shows them.
    bit prevBusy = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (checkEn) begin
                chk("done_and_timeout", int'(done && timeout_err), 0);
                if (busy) begin
                    chk("gnt_onehot", int'(gnt), 1 << gnt_id);
                end else begin
                    chk("idle_gnt", int'(gnt), 0);
                    chk("idle_gnt_id", int'(gnt_id), 0);
                    chk("idle_done", int'(done), 0);
                    chk("idle_timeout", int'(timeout_err), 0);
                end
                if (busy && !prevBusy) expectEv("grant", EV_GRANT, int'(gnt_id));
                if (done) expectEv("done", EV_DONE, int'(gnt_id));
                if (timeout_err) expectEv("timeout", EV_TOUT, int'(gnt_id));
            end
            prevBusy = busy;
        end
    end

    task automatic drain();
        int n = 0;
        while (mBusy && n < 100) begin
            step('0, '0, 1'b1, 1'b1);
            n++;
        end
        chk("drain_bound", int'(mBusy), 0);
        step('0, '0, 1'b0, 1'b1);
        step('0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        logic [N-1:0]    r;
        logic [N*LW-1:0] l;
        logic            a;

        step('0, '0, 1'b0, 1'b0);
        step('0, '0, 1'b0, 1'b0);
        checkEn = 1;

        // Idle after reset, with a stray ack that must be ignored.
        for (int i = 0; i < 5; i++) step('0, '0, (i == 2), 1'b1);

        // Single burst of 3 on requester 2.
        step(4'b0100, 16'h0300, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0000, 16'h0300, 1'b1, 1'b1);
        drain();

        // Round robin, all lengths 1; ptr now 3 so order starts at 3.
        for (int i = 0; i < 12; i++) step(4'b1111, 16'h1111, 1'b1, 1'b1);
        drain();

        // Wrap and skip: grant 2 leaves ptr=3, then requesters 0 and 1 only.
        step(4'b0100, 16'h0100, 1'b1, 1'b1);
        step(4'b0000, 16'h0100, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) step(4'b0011, 16'h0011, 1'b1, 1'b1);
        drain();

        // Timeout on requester 1 (length 4): two acks then silence; requester 3 waits.
        step(4'b0010, 16'h0040, 1'b0, 1'b1);
        step(4'b1010, 16'h2040, 1'b1, 1'b1);
        step(4'b1010, 16'h2040, 1'b1, 1'b1);
        for (int i = 0; i < TO + 3; i++) step(4'b1010, 16'h2040, 1'b0, 1'b1);
        drain();

        // Zero length completes after one ack.
        step(4'b1000, 16'h0000, 1'b0, 1'b1);
        step(4'b0000, 16'h0000, 1'b1, 1'b1);
        drain();

        // Granted requester drops req mid-burst; grant held to completion.
        step(4'b0001, 16'h0005, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(4'b0000, 16'h0000, (i % 2 == 0), 1'b1);
        drain();

        // Reset while busy, with an ack that would otherwise finish the burst.
        step(4'b0100, 16'h0200, 1'b0, 1'b1);
        step(4'b0100, 16'h0200, 1'b1, 1'b1);
        step(4'b0100, 16'h0200, 1'b1, 1'b0);
        step(4'b0000, 16'h0000, 1'b0, 1'b1);
        step(4'b0000, 16'h0000, 1'b0, 1'b1);

        // Random traffic with alternating ack-rich and stall-heavy phases.
        r = '0;
        l = '0;
        for (int blk = 0; blk < 12; blk++) begin
            for (int i = 0; i < 200; i++) begin
                if ($urandom_range(0, 3) == 0) r = N'($urandom_range(0, (1 << N) - 1));
                if ($urandom_range(0, 3) == 0) l = (N*LW)'($urandom);
                if (blk % 3 == 2) a = ($urandom_range(0, 19) == 0);
                else a = ($urandom_range(0, 3) != 0);
                step(r, l, a, ($urandom_range(0, 499) != 0));
            end
        end
        drain();

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
